pong_layer_renderer: RTL and testbench
======================================

// Module: pong_layer_renderer
// PURPOSE
//  Successor to the single-colour pong drawer. Renders NUM_PADDLES paddles plus one ball with
//  per-object colours, fixed priority and enable mask. Sits between game logic and vga_driver.
//  Object positions are double-buffered and latched once per frame, so updates never tear.
//  Output path is a 2-stage pipeline. Ball/paddle pixel overlap is reported per frame as a
//  hardware collision flag.
// PARAMETERS
//  NUM_PADDLES    2     number of paddles (1..4)
//  PADDLE_WIDTH   20    paddle width, px
//  PADDLE_HEIGHT  160   paddle height, px (even)
//  BALL_SIDE      30    ball side, px (even)
//  FRAME_WIDTH    1280  visible columns
//  FRAME_HEIGHT   960   visible lines
//  CNT_W          14    hCntr/vCntr width
//  POS_W          12    position width
//  COLOR_W        12    RGB width (4:4:4)
// PORTS
//  pxClk          in   1                pixel clock
//  rst            in   1                asynchronous, active-high reset
//  hCntr          in   CNT_W            current column, from vga_driver
//  vCntr          in   CNT_W            current line, from vga_driver
//  paddle_px      in   NUM_PADDLES*POS_W  left edge of paddle i, slice [i*POS_W +: POS_W]
//  paddle_py      in   NUM_PADDLES*POS_W  vertical centre of paddle i
//  ball_px        in   POS_W            ball centre x
//  ball_py        in   POS_W            ball centre y
//  obj_en         in   NUM_PADDLES+1    enables; bit NUM_PADDLES = ball
//  paddle_color   in   COLOR_W          colour of all paddles
//  ball_color     in   COLOR_W          ball colour
//  bg_color       in   COLOR_W          visible-area background colour
//  rgb_out        out  COLOR_W          pixel for (hCntr,vCntr) sampled 2 cycles earlier
//  frame_latch    out  1                1-cycle pulse when shadow registers load
//  hit_pulse      out  1                1-cycle pulse with frame_latch if any hit last frame
//  hit_mask       out  NUM_PADDLES      paddles that overlapped the ball last frame
// BEHAVIOUR
//  Reset: all shadows, pipeline regs, sticky bits and outputs = 0 (objects disabled, rgb_out 0).
//  Latch event: hCntr==0 && vCntr==FRAME_HEIGHT (first blanking line). On that cycle:
//   - shadow pos/en/colour regs <= inputs
//   - hit_mask <= sticky
//   - hit_pulse <= |sticky
//   - sticky <= 0
//   - frame_latch <= 1
//  All three outputs are registered and valid the next cycle. Inputs are ignored at all other times.
//  Visible = hCntr<FRAME_WIDTH && vCntr<FRAME_HEIGHT; non-visible -> rgb_out = 0.
//  Rectangle tests use CNT_W+1-bit unsigned arithmetic. Subtract nothing, so no underflow:
//   - paddle i: px <= h < px+PADDLE_WIDTH;  v+PADDLE_HEIGHT/2 >= py && v < py+PADDLE_HEIGHT/2
//   - ball:     h+BALL_SIDE/2 >= bx && h < bx+BALL_SIDE/2;  same form in y with by
//   - object hit requires its shadow enable bit set.
//  Stage 1: register the per-object hit bits and the visible bit.
//  Stage 2: priority compose, register rgb_out:
//   - ball > paddle (any) > bg_color; non-visible -> 0.
//  Latency: rgb_out lags hCntr/vCntr by exactly 2 pxClk cycles; vga_driver compensates.
//  Collision: a stage-1 pixel that is visible with ball hit and paddle i hit sets sticky[i].
//   - Latch occurs in blanking, so set and clear never coincide.
//   - If they did, clear wins.
//  Objects partially off-screen are clipped by the visible test; positions near 0 or max do not wrap.
//  rst asserted mid-frame: everything returns to reset state immediately. Screen shows
//  rgb_out=0 until rst is released; objects stay disabled until the next latch event.
// STRUCTURE
//  pong_pkg: frame/object default constants and the colour-width localparam.
//  Sub-module pong_rect_hit (params W,H,centred-x flag): one rectangle compare, combinational.
//  NUM_PADDLES+1 instances are made via generate, with outputs registered in the parent.
// TESTING
//  1 Reset mid-frame, release: rgb_out=0 everywhere until first latch, frame_latch pulses at
//    h=0,v=960.
//  2 Ball at (640,480), all enabled: pixels h=625..654, v=465..494 show ball_color 2 cycles
//    later; h=624 and h=655 show bg_color.
//  3 Change ball_px mid-frame: no pixel of the current frame moves; new position visible from
//    next frame.
//  4 Paddle0 px=20 py=480, ball at (30,480): next latch gives hit_pulse=1, hit_mask=2'b01,
//    with overlap pixels showing ball_color. The frame after gives hit_pulse=0.
//  5 obj_en=3'b011 with ball overlapping paddle1: paddle_color shown, hit_mask=0.
//  6 Paddle py=10: only v=0..89 drawn, no wrap at v near 960; h>=1280 gives rgb_out=0.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: default frame/object geometry and colour width shared by the pong renderer.
package pong_pkg;
  localparam int NUM_PADDLES_DEF   = 2;
  localparam int PADDLE_WIDTH_DEF  = 20;
  localparam int PADDLE_HEIGHT_DEF = 160;
  localparam int BALL_SIDE_DEF     = 30;
  localparam int FRAME_WIDTH_DEF   = 1280;
  localparam int FRAME_HEIGHT_DEF  = 960;
  localparam int CNT_W_DEF         = 14;
  localparam int POS_W_DEF         = 12;
  localparam int COLOR_W           = 12;
endpackage

// File: rtl/pong_rect_hit.sv
// pong_rect_hit: combinational point-in-rectangle test; positions are widened so nothing is subtracted.
module pong_rect_hit #(
  parameter int W         = 20,
  parameter int H         = 160,
  parameter bit CENTRED_X = 1'b0,
  parameter int CNT_W     = 14,
  parameter int POS_W     = 12
) (
  input  logic [CNT_W-1:0] h_i,
  input  logic [CNT_W-1:0] v_i,
  input  logic [POS_W-1:0] px_i,
  input  logic [POS_W-1:0] py_i,
  input  logic             en_i,
  output logic             hit_o
);
  localparam logic [CNT_W:0] XS = (CNT_W+1)'(CENTRED_X ? W / 2 : W);
  localparam logic [CNT_W:0] YS = (CNT_W+1)'(H / 2);
  logic [CNT_W:0] h, v, x, y;
  logic           lo_x;
  assign h     = {1'b0, h_i};
  assign v     = {1'b0, v_i};
  assign x     = (CNT_W+1)'(px_i);
  assign y     = (CNT_W+1)'(py_i);
  assign lo_x  = CENTRED_X ? (h + XS >= x) : (h >= x);
  assign hit_o = en_i && lo_x && (h < x + XS) && (v + YS >= y) && (v < y + YS);
endmodule

// File: rtl/pong_layer_renderer.sv
// pong_layer_renderer: per-frame latched paddles + ball renderer with 2-stage pixel pipeline
// and per-frame ball/paddle collision reporting.
module pong_layer_renderer
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES   = NUM_PADDLES_DEF,
  parameter int PADDLE_WIDTH  = PADDLE_WIDTH_DEF,
  parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEF,
  parameter int BALL_SIDE     = BALL_SIDE_DEF,
  parameter int FRAME_WIDTH   = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT  = FRAME_HEIGHT_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int POS_W         = POS_W_DEF,
  parameter int CW            = COLOR_W
) (
  input  logic                         pxClk,
  input  logic                         rst,
  input  logic [CNT_W-1:0]             hCntr,
  input  logic [CNT_W-1:0]             vCntr,
  input  logic [NUM_PADDLES*POS_W-1:0] paddle_px,
  input  logic [NUM_PADDLES*POS_W-1:0] paddle_py,
  input  logic [POS_W-1:0]             ball_px,
  input  logic [POS_W-1:0]             ball_py,
  input  logic [NUM_PADDLES:0]         obj_en,
  input  logic [CW-1:0]                paddle_color,
  input  logic [CW-1:0]                ball_color,
  input  logic [CW-1:0]                bg_color,
  output logic [CW-1:0]                rgb_out,
  output logic                         frame_latch,
  output logic                         hit_pulse,
  output logic [NUM_PADDLES-1:0]       hit_mask
);
  localparam int NP = NUM_PADDLES;
  logic [NP*POS_W-1:0] ppx_q, ppy_q;
  logic [POS_W-1:0]    bpx_q, bpy_q;
  logic [NP:0]         en_q;
  logic [CW-1:0]       pcol_q, bcol_q, bgcol_q;
  logic [NP:0]         hit_d, hit_q;
  logic                vis_d, vis_q;
  logic [CW-1:0]       rgb_d, rgb_q;
  logic [NP-1:0]       sticky_d, sticky_q, hit_mask_q;
  logic                latch, frame_latch_q, hit_pulse_q;
  assign latch = (hCntr == '0) && (vCntr == CNT_W'(FRAME_HEIGHT));
  assign vis_d = (hCntr < CNT_W'(FRAME_WIDTH)) && (vCntr < CNT_W'(FRAME_HEIGHT));
  genvar p;
  generate
    for (p = 0; p < NP; p++) begin : g_pad
      pong_rect_hit #(.W(PADDLE_WIDTH), .H(PADDLE_HEIGHT), .CENTRED_X(1'b0), .CNT_W(CNT_W), .POS_W(POS_W)) u_pad (
        .h_i(hCntr), .v_i(vCntr), .px_i(ppx_q[p*POS_W +: POS_W]), .py_i(ppy_q[p*POS_W +: POS_W]),
        .en_i(en_q[p]), .hit_o(hit_d[p])
      );
    end
  endgenerate
  pong_rect_hit #(.W(BALL_SIDE), .H(BALL_SIDE), .CENTRED_X(1'b1), .CNT_W(CNT_W), .POS_W(POS_W)) u_ball (
    .h_i(hCntr), .v_i(vCntr), .px_i(bpx_q), .py_i(bpy_q), .en_i(en_q[NP]), .hit_o(hit_d[NP])
  );
  always_comb begin
    rgb_d    = !vis_q ? '0 : hit_q[NP] ? bcol_q : (|hit_q[NP-1:0]) ? pcol_q : bgcol_q;
    // latch only happens in blanking, but clear still takes precedence over set
    sticky_d = latch ? '0 : sticky_q | ({NP{vis_q & hit_q[NP]}} & hit_q[NP-1:0]);
  end
  always_ff @(posedge pxClk or posedge rst) begin
    if (rst) begin
      ppx_q         <= '0;
      ppy_q         <= '0;
      bpx_q         <= '0;
      bpy_q         <= '0;
      en_q          <= '0;
      pcol_q        <= '0;
      bcol_q        <= '0;
      bgcol_q       <= '0;
      hit_q         <= '0;
      vis_q         <= 1'b0;
      rgb_q         <= '0;
      sticky_q      <= '0;
      hit_mask_q    <= '0;
      frame_latch_q <= 1'b0;
      hit_pulse_q   <= 1'b0;
    end else begin
      if (latch) begin
        ppx_q      <= paddle_px;
        ppy_q      <= paddle_py;
        bpx_q      <= ball_px;
        bpy_q      <= ball_py;
        en_q       <= obj_en;
        pcol_q     <= paddle_color;
        bcol_q     <= ball_color;
        bgcol_q    <= bg_color;
        hit_mask_q <= sticky_q;
      end
      hit_q         <= hit_d;
      vis_q         <= vis_d;
      rgb_q         <= rgb_d;
      sticky_q      <= sticky_d;
      frame_latch_q <= latch;
      hit_pulse_q   <= latch & (|sticky_q);
    end
  end
  assign rgb_out     = rgb_q;
  assign frame_latch = frame_latch_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_mask    = hit_mask_q;
endmodule

// File: tb/tb_pong_layer_renderer.sv
// tb_pong_layer_renderer: directed tests of the layered pong renderer with hand-computed pixels.
module tb_pong_layer_renderer;
  localparam logic [11:0] PC = 12'h0F0;
  localparam logic [11:0] BC = 12'hF00;
  localparam logic [11:0] GC = 12'h00F;
  logic        pxClk = 1'b0;
  logic        rst;
  logic [13:0] hCntr, vCntr;
  logic [23:0] paddle_px, paddle_py;
  logic [11:0] ball_px, ball_py;
  logic [2:0]  obj_en;
  logic [11:0] paddle_color, ball_color, bg_color;
  logic [11:0] rgb_out;
  logic        frame_latch, hit_pulse;
  logic [1:0]  hit_mask;
  int total = 0;
  int bad = 0;

  pong_layer_renderer dut (
    .pxClk(pxClk), .rst(rst), .hCntr(hCntr), .vCntr(vCntr),
    .paddle_px(paddle_px), .paddle_py(paddle_py), .ball_px(ball_px), .ball_py(ball_py),
    .obj_en(obj_en), .paddle_color(paddle_color), .ball_color(ball_color), .bg_color(bg_color),
    .rgb_out(rgb_out), .frame_latch(frame_latch), .hit_pulse(hit_pulse), .hit_mask(hit_mask)
  );

  always #5 pxClk = ~pxClk;

  task automatic idle();
    hCntr = 14'd1300;
    vCntr = 14'd1000;
  endtask

  task automatic pix(input logic [13:0] h, input logic [13:0] v, output logic [11:0] c);
    @(negedge pxClk);
    hCntr = h;
    vCntr = v;
    @(negedge pxClk);
    idle();
    @(negedge pxClk);
    c = rgb_out;
  endtask

  task automatic do_latch();
    @(negedge pxClk);
    hCntr = 14'd0;
    vCntr = 14'd960;
    @(negedge pxClk);
    idle();
  endtask

  task automatic test_reset();
    logic [11:0] c;
    @(negedge pxClk);
    total++;
    if ({rgb_out, frame_latch, hit_pulse, hit_mask} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {rgb_out, frame_latch, hit_pulse, hit_mask});
    end
    rst = 1'b0;
    pix(14'd640, 14'd480, c);
    total++;
    if (c !== 12'h000) begin bad++; $display("FAIL prelatch_ball got=%h exp=000", c); end
    pix(14'd0, 14'd0, c);
    total++;
    if (c !== 12'h000) begin bad++; $display("FAIL prelatch_bg got=%h exp=000", c); end
    @(negedge pxClk);
    hCntr = 14'd0;
    vCntr = 14'd959;
    @(negedge pxClk);
    idle();
    total++;
    if (frame_latch !== 1'b0) begin bad++; $display("FAIL no_latch_v959 got=%b exp=0", frame_latch); end
    do_latch();
    total++;
    if ({frame_latch, hit_pulse, hit_mask} !== 4'b1000) begin
      bad++;
      $display("FAIL first_latch got=%b exp=1000", {frame_latch, hit_pulse, hit_mask});
    end
    @(negedge pxClk);
    total++;
    if (frame_latch !== 1'b0) begin bad++; $display("FAIL latch_one_cycle got=%b exp=0", frame_latch); end
  endtask

  task automatic test_ball_edges();
    logic [13:0] hs[10] = '{640, 625, 654, 624, 655, 640, 640, 640, 20, 19};
    logic [13:0] vs[10] = '{480, 480, 480, 480, 480, 465, 494, 464, 480, 480};
    logic [11:0] ex[10] = '{BC, BC, BC, GC, GC, BC, BC, GC, PC, GC};
    logic [11:0] c;
    for (int i = 0; i < 10; i++) begin
      pix(hs[i], vs[i], c);
      total++;
      if (c !== ex[i]) begin
        bad++;
        $display("FAIL ball_edge h=%0d v=%0d got=%h exp=%h", hs[i], vs[i], c, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    for (int k = 0; k < 38; k++) begin
      @(negedge pxClk);
      if (k >= 2) begin
        e = (622 + k - 2 >= 625 && 622 + k - 2 <= 654) ? BC : GC;
        total++;
        if (rgb_out !== e) begin
          bad++;
          $display("FAIL stream h=%0d got=%h exp=%h", 622 + k - 2, rgb_out, e);
        end
      end
      if (k < 36) begin
        hCntr = 14'(622 + k);
        vCntr = 14'd480;
      end else idle();
    end
  endtask

  task automatic test_mid_frame_update();
    logic [13:0] hs[4] = '{640, 900, 900, 640};
    logic [11:0] ex[4] = '{BC, GC, BC, GC};
    logic [11:0] c;
    ball_px = 12'd900;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) do_latch();
      pix(hs[i], 14'd480, c);
      total++;
      if (c !== ex[i]) begin
        bad++;
        $display("FAIL update_frame i=%0d h=%0d got=%h exp=%h", i, hs[i], c, ex[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [11:0] c;
    paddle_px = {12'd1200, 12'd20};
    ball_px   = 12'd30;
    ball_py   = 12'd480;
    do_latch();
    total++;
    if ({hit_pulse, hit_mask} !== 3'b000) begin
      bad++;
      $display("FAIL precollision_latch got=%b exp=000", {hit_pulse, hit_mask});
    end
    pix(14'd30, 14'd480, c);
    total++;
    if (c !== BC) begin bad++; $display("FAIL overlap_pixel got=%h exp=%h", c, BC); end
    do_latch();
    total++;
    if ({frame_latch, hit_pulse, hit_mask} !== 4'b1101) begin
      bad++;
      $display("FAIL collision_latch got=%b exp=1101", {frame_latch, hit_pulse, hit_mask});
    end
    @(negedge pxClk);
    total++;
    if ({hit_pulse, hit_mask} !== 3'b001) begin
      bad++;
      $display("FAIL collision_hold got=%b exp=001", {hit_pulse, hit_mask});
    end
    do_latch();
    total++;
    if ({hit_pulse, hit_mask} !== 3'b000) begin
      bad++;
      $display("FAIL collision_cleared got=%b exp=000", {hit_pulse, hit_mask});
    end
  endtask

  task automatic test_enable_mask();
    logic [13:0] hs[4] = '{640, 645, 655, 629};
    logic [11:0] ex[4] = '{PC, PC, GC, GC};
    logic [11:0] c;
    obj_en    = 3'b011;
    paddle_px = {12'd630, 12'd20};
    ball_px   = 12'd640;
    do_latch();
    for (int i = 0; i < 4; i++) begin
      pix(hs[i], 14'd480, c);
      total++;
      if (c !== ex[i]) begin
        bad++;
        $display("FAIL masked_ball h=%0d got=%h exp=%h", hs[i], c, ex[i]);
      end
    end
    do_latch();
    total++;
    if ({hit_pulse, hit_mask} !== 3'b000) begin
      bad++;
      $display("FAIL masked_hit got=%b exp=000", {hit_pulse, hit_mask});
    end
  endtask

  task automatic test_clip();
    logic [13:0] hs[9] = '{25, 25, 25, 25, 1279, 1280, 1300, 640, 25};
    logic [13:0] vs[9] = '{0, 89, 90, 959, 480, 480, 480, 480, 960};
    logic [11:0] ex[9] = '{PC, PC, GC, GC, PC, 12'h000, 12'h000, BC, 12'h000};
    logic [11:0] c;
    obj_en    = 3'b111;
    paddle_px = {12'd1270, 12'd20};
    paddle_py = {12'd480, 12'd10};
    do_latch();
    for (int i = 0; i < 9; i++) begin
      pix(hs[i], vs[i], c);
      total++;
      if (c !== ex[i]) begin
        bad++;
        $display("FAIL clip h=%0d v=%0d got=%h exp=%h", hs[i], vs[i], c, ex[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] c;
    @(negedge pxClk);
    hCntr = 14'd640;
    vCntr = 14'd480;
    repeat (3) @(negedge pxClk);
    total++;
    if (rgb_out !== BC) begin bad++; $display("FAIL before_rst got=%h exp=%h", rgb_out, BC); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rgb_out, frame_latch, hit_pulse, hit_mask} !== 16'h0) begin
      bad++;
      $display("FAIL async_rst got=%h exp=0", {rgb_out, frame_latch, hit_pulse, hit_mask});
    end
    @(negedge pxClk);
    rst = 1'b0;
    repeat (3) @(negedge pxClk);
    total++;
    if (rgb_out !== 12'h000) begin bad++; $display("FAIL after_rst got=%h exp=000", rgb_out); end
    idle();
    do_latch();
    pix(14'd640, 14'd480, c);
    total++;
    if (c !== BC) begin bad++; $display("FAIL relatch got=%h exp=%h", c, BC); end
  endtask

  initial begin
    rst          = 1'b1;
    paddle_px    = {12'd1200, 12'd20};
    paddle_py    = {12'd480, 12'd480};
    ball_px      = 12'd640;
    ball_py      = 12'd480;
    obj_en       = 3'b111;
    paddle_color = PC;
    ball_color   = BC;
    bg_color     = GC;
    idle();
    test_reset();
    test_ball_edges();
    test_back_to_back();
    test_mid_frame_update();
    test_collision();
    test_enable_mask();
    test_clip();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
